// File: rtl/iomem_bus_pkg.sv
// rtl/iomem_bus_pkg.sv - shared types and constants for the iomem bus controller
package iomem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;
  localparam int          IDX_LSB   = 12;
  localparam int          IDX_W     = 4;
  localparam int          ERR_CNT_W = 16;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/iomem_timeout_ctr.sv
// rtl/iomem_timeout_ctr.sv - slave wait counter, flags the LIMIT-th cycle without ready
module iomem_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // r_cnt counts earlier ready-less cycles, so this fires on the LIMIT-th one
  assign o_expire = i_enable && (r_cnt == 16'(LIMIT - 1));

endmodule

// File: rtl/iomem_bus_ctrl.sv
// rtl/iomem_bus_ctrl.sv - PicoSoC iomem I/O-page decoder and slave sequencer
// Optional slave timeout: define IOMEM_TIMEOUT_EN.
module iomem_bus_ctrl
  import iomem_bus_pkg::*;
#(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [7:0]  IO_PAGE        = 8'h03,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iomem_valid,
  output logic                     iomem_ready,
  input  logic [3:0]               iomem_wstrb,
  input  logic [31:0]              iomem_addr,
  input  logic [31:0]              iomem_wdata,
  output logic [31:0]              iomem_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  output logic [ERR_CNT_W-1:0]     err_count,
  output logic                     irq_err
);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_ready;
  logic [31:0]            r_rdata;
  logic [NUM_SLAVES-1:0]  r_s_valid;
  logic [31:0]            r_s_addr;
  logic [31:0]            r_s_wdata;
  logic [3:0]             r_s_wstrb;
  logic [ERR_CNT_W-1:0]   r_err_cnt;
  logic                   r_irq;

  logic [IDX_W-1:0]       w_idx;
  logic                   w_accept;
  logic                   w_decoded;
  logic [NUM_SLAVES-1:0]  w_onehot;
  logic                   w_sel_ready;
  logic [31:0]            w_sel_rdata;
  logic                   w_timeout;

  assign w_idx     = iomem_addr[IDX_LSB +: IDX_W];
  assign w_decoded = ({1'b0, w_idx} < 5'(NUM_SLAVES));
  // r_ready blocks re-acceptance while the requester still holds valid
  assign w_accept  = (r_state == IDLE) && iomem_valid && !r_ready &&
                     (iomem_addr[31:24] == IO_PAGE);

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_idx == IDX_W'(i)) w_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_ready = s_ready[i];
        w_sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

`ifdef IOMEM_TIMEOUT_EN
  iomem_timeout_ctr #(
    .LIMIT    (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (reset),
    .i_clear  (w_accept),
    .i_enable ((r_state == ACCESS) && !w_sel_ready),
    .o_expire (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_s_valid <= '0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_wstrb <= '0;
      r_err_cnt <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_irq   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_s_addr  <= iomem_addr;
            r_s_wdata <= iomem_wdata;
            r_s_wstrb <= iomem_wstrb;
            r_idx     <= w_idx;
            if (w_decoded) begin
              r_s_valid <= w_onehot;
              r_state   <= ACCESS;
            end else begin
              r_state   <= ERR;
            end
          end
        end
        ACCESS: begin
          // a ready arriving on the timeout cycle still completes normally
          if (w_sel_ready) begin
            r_rdata   <= w_sel_rdata;
            r_s_valid <= '0;
            r_state   <= RESP;
          end else if (w_timeout) begin
            r_s_valid <= '0;
            r_state   <= ERR;
          end
        end
        RESP: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        ERR: begin
          r_ready   <= 1'b1;
          r_rdata   <= ERR_DATA;
          r_irq     <= 1'b1;
          r_err_cnt <= sat_inc(r_err_cnt);
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign s_valid     = r_s_valid;
  assign s_addr      = r_s_addr;
  assign s_wdata     = r_s_wdata;
  assign s_wstrb     = r_s_wstrb;
  assign err_count   = r_err_cnt;
  assign irq_err     = r_irq;

endmodule

// File: tb/tb_iomem_bus_ctrl.sv
// tb/tb_iomem_bus_ctrl.sv - self-checking bench for iomem_bus_ctrl
module tb_iomem_bus_ctrl;

  localparam int NS = 4;
  localparam int TO = 8;
`ifdef IOMEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          iomem_valid = 1'b0;
  logic          iomem_ready;
  logic [3:0]    iomem_wstrb = '0;
  logic [31:0]   iomem_addr = '0;
  logic [31:0]   iomem_wdata = '0;
  logic [31:0]   iomem_rdata;
  logic [NS-1:0] s_valid;
  logic [NS-1:0] s_ready = '0;
  logic [32*NS-1:0] s_rdata = '0;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic [15:0]   err_count;
  logic          irq_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  logic [31:0] slave_data [NS];
  logic [15:0] exp_err = '0;

  iomem_bus_ctrl #(
    .NUM_SLAVES     (NS),
    .IO_PAGE        (8'h03),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .err_count   (err_count),
    .irq_err     (irq_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_slaves();
    for (int i = 0; i < NS; i++) slave_data[i] = $urandom;
  endtask

  // Expected behaviour derived from the bus rules: latency = slave cycles + 2,
  // decode errors spend zero slave cycles, timeouts spend exactly TO.
  task automatic do_req(input logic [31:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input int wait_c);
    logic [3:0]    idx;
    logic [NS-1:0] exp_oh;
    logic [31:0]   exp_rd;
    bit in_page, decoded, timed_out, to_err, got;
    int exp_sv, exp_lat, sv_seen, lat, budget;

    idx       = addr[15:12];
    in_page   = (addr[31:24] == 8'h03);
    decoded   = in_page && (int'(idx) < NS);
    timed_out = decoded && TO_EN && (wait_c >= TO);
    to_err    = in_page && (!decoded || timed_out);
    exp_oh    = '0;
    if (decoded) exp_oh[idx[1:0]] = 1'b1;
    exp_sv    = !decoded ? 0 : (timed_out ? TO : wait_c + 1);
    exp_lat   = exp_sv + 2;
    exp_rd    = to_err ? 32'hDEAD_BEEF : slave_data[idx[1:0]];
    if (to_err && exp_err != 16'hFFFF) exp_err++;
    budget    = in_page ? exp_lat + 8 : 20;
    got = 0; sv_seen = 0; lat = 0;

    @(negedge clk);
    for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = slave_data[i];
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    s_ready     = NS'($urandom) & ~exp_oh;

    for (int c = 1; c <= budget && !got; c++) begin
      @(posedge clk); #1;
      if (s_valid !== '0) begin
        sv_seen++;
        check("s_valid_onehot", s_valid, exp_oh);
        check("s_bus_latched", {s_addr, s_wdata, s_wstrb}, {addr, wdata, wstrb});
      end
      if (iomem_ready === 1'b1) begin
        got = 1;
        lat = c;
        check("rdata", iomem_rdata, exp_rd);
        check("irq_err", irq_err, to_err);
        check("err_count", err_count, exp_err);
      end
      s_ready = NS'($urandom) & ~exp_oh;
      if (s_valid !== '0 && sv_seen > wait_c) s_ready = s_ready | exp_oh;
    end

    if (in_page) begin
      check("ready_seen", got, 1);
      check("latency", lat, exp_lat);
      check("s_valid_cycles", sv_seen, exp_sv);
      @(posedge clk); #1;
      check("no_reaccept", {iomem_ready, s_valid}, 0);
      @(negedge clk);
      iomem_valid = 1'b0;
      s_ready = '0;
      @(posedge clk); #1;
      check("ready_single", iomem_ready, 0);
    end else begin
      check("offpage_ready", got, 0);
      check("offpage_s_valid", sv_seen, 0);
      check("offpage_err_count", err_count, exp_err);
      @(negedge clk);
      iomem_valid = 1'b0;
      s_ready = '0;
    end
  endtask

  initial begin
    logic [31:0] a;
    int w;

    repeat (2) @(negedge clk);
    check("reset_out_a", {iomem_ready, iomem_rdata, s_valid, irq_err, err_count}, 0);
    check("reset_out_b", {s_addr, s_wdata, s_wstrb}, 0);
    reset = 1'b0;

    randomize_slaves();
    do_req(32'h0200_0000, 4'h0, 32'h0, 0);
    check("offpage_out_a", {iomem_ready, iomem_rdata, s_valid, irq_err, err_count}, 0);
    check("offpage_out_b", {s_addr, s_wdata, s_wstrb}, 0);

    randomize_slaves();
    slave_data[1] = 32'h1234_5678;
    do_req(32'h0300_1004, 4'h0, 32'h0, 0);

    randomize_slaves();
    do_req(32'h0300_0000, 4'hF, 32'hA5A5_0001, 5);

    randomize_slaves();
    do_req(32'h0300_7000, 4'h0, 32'h0, 0);
    check("decode_err_count", err_count, 16'd1);

`ifdef IOMEM_TIMEOUT_EN
    randomize_slaves();
    do_req(32'h0300_2000, 4'h0, 32'h0, 1000);
    randomize_slaves();
    do_req(32'h0300_2000, 4'h0, 32'h0, TO - 1);
`else
    randomize_slaves();
    do_req(32'h0300_2000, 4'h0, 32'h0, 40);
`endif

    for (int t = 0; t < 40; t++) begin
      randomize_slaves();
      a = {8'h03, 8'($urandom), 4'($urandom_range(0, 7)), 12'($urandom)};
      if ($urandom_range(0, 7) == 0) a[31:24] = 8'h05;
      w = TO_EN ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 4));
      do_req(a, 4'($urandom), $urandom, w);
    end

    randomize_slaves();
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_3008;
    iomem_wstrb = 4'h0;
    s_ready     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_s_valid", s_valid, 4'b1000);
    #2 reset = 1'b1;
    #1;
    check("async_reset_drop", {s_valid, iomem_ready, irq_err, err_count}, 0);
    @(negedge clk);
    iomem_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_err = '0;

    randomize_slaves();
    do_req(32'h0300_3010, 4'h3, 32'hCAFE_0042, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/iomem_bus_ctrl.md
Name: iomem_bus_ctrl

Overview:
- Controller for the PicoSoC iomem bus.
- Decodes CPU iomem requests in the I/O page (addr[31:24] == IO_PAGE) and steers each one to one of NUM_SLAVES peripheral windows, 4 KB each, selected by addr[15:12].
- Sequences the slave handshake and returns one registered ready/rdata to the CPU.
- Answers undecoded or hung accesses with an error word, so the CPU never stalls on the I/O page.

Parameters:
- NUM_SLAVES, 4, number of peripheral windows (1..16); window index = addr[15:12].
- IO_PAGE, 8'h03, value of addr[31:24] claimed by this block.
- TIMEOUT_CYCLES, 255, maximum cycles s_valid is held without s_ready before an error response (1..65535).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- iomem_valid  in  1  CPU request valid; held until iomem_ready.
- iomem_ready  out  1  one-cycle registered completion pulse.
- iomem_wstrb  in  4  byte write strobes; 0 means read.
- iomem_addr  in  32  request address.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  registered read data; valid while iomem_ready=1.
- s_valid  out  NUM_SLAVES  one-hot slave request.
- s_ready  in  NUM_SLAVES  slave completion, per slave.
- s_rdata  in  32*NUM_SLAVES  slave read data; slave i occupies bits [32*i+31:32*i].
- s_addr  out  32  latched request address, broadcast to all slaves.
- s_wdata  out  32  latched write data, broadcast.
- s_wstrb  out  4  latched strobes, broadcast.
- err_count  out  16  saturating count of decode and timeout errors.
- irq_err  out  1  one-cycle pulse per error response.

Behaviour:
- Reset: asynchronous; while reset is high, all outputs are 0 and the FSM is IDLE. Asserting reset mid-access drops s_valid immediately; the slave transaction is abandoned without a response.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - iomem_valid && iomem_addr[31:24]==IO_PAGE → latch addr/wdata/wstrb and index idx=addr[15:12].
  - idx < NUM_SLAVES → ACCESS; otherwise → ERR.
  - Requests outside the page are ignored; iomem_ready stays 0 so other decoders can respond.
- ACCESS:
  - s_valid[idx]=1, registered, first asserted the cycle after the request is accepted.
  - s_ready[idx]=1 → capture s_rdata[idx] into iomem_rdata, drop s_valid, → RESP.
  - Ready from any other slave is ignored.
- RESP: iomem_ready=1 for exactly one cycle, then → IDLE.
- ERR: iomem_ready=1 for one cycle; iomem_rdata=32'hDEAD_BEEF; irq_err=1; err_count increments, saturating at 16'hFFFF; then → IDLE.
- Latency:
  - A slave with combinational ready produces iomem_ready 3 cycles after iomem_valid is first sampled (accept, slave cycle, RESP).
  - A decode error produces iomem_ready 2 cycles after the request.
- Writes: the slave commits the write on s_valid && s_ready; this block's iomem_rdata on a write is the slave's s_rdata.
- Re-acceptance: the requester drops iomem_valid in the cycle after iomem_ready. IDLE never accepts a request in the same cycle iomem_ready is high.
- s_addr/s_wdata/s_wstrb stay stable from acceptance until the next accepted request.

Optional Feature:
IOMEM_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments each cycle without s_ready[idx].
  - When the count reaches TIMEOUT_CYCLES, s_valid drops and the FSM goes to ERR.
  - If s_ready arrives in the same cycle as the timeout, ready wins and the FSM goes to RESP.
- Undefined: ACCESS waits indefinitely; decode errors are the only source of irq_err and err_count increments.

Decomposition:
- Package iomem_bus_pkg:
  - state enum (IDLE, ACCESS, RESP, ERR);
  - ERR_DATA = 32'hDEAD_BEEF;
  - IDX_LSB = 12 and IDX_W = 4 (window-select field);
  - ERR_CNT_W = 16.
- Sub-module iomem_timeout_ctr: clear, enable, terminal-count compare, instantiated only under IOMEM_TIMEOUT_EN.

Test Plan:
- Read slave 1, addr 0x0300_1004, s_ready[1] combinational, s_rdata[1]=0x1234_5678 → s_valid=4'b0010 for 1 cycle; iomem_ready 3 cycles after valid; iomem_rdata=0x1234_5678.
- Write, wstrb=4'hF, wdata=0xA5A5_0001, slave 0 ready after 5 wait cycles → s_valid[0] held 6 cycles; s_wdata stable throughout; single iomem_ready pulse.
- Address 0x0300_7000 with NUM_SLAVES=4 → no s_valid; iomem_ready 2 cycles later with rdata 0xDEADBEEF; irq_err pulse; err_count=1.
- Address 0x0200_0000 → no response; all outputs stay 0 for 20 cycles.
- IOMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave 2 never ready → s_valid[2] drops after 8 cycles; ERR response; err_count increments. Repeat with s_ready[2] on cycle 8 → normal RESP.
- Reset asserted while in ACCESS → s_valid=0 asynchronously; FSM back in IDLE; err_count=0; the next request completes normally.
